// File: rtl/demux1x4_stream.sv
// demux1x4_stream: registered 1-to-4 stream demultiplexer.
// One valid/ready input stream is steered into one of four output channels.
// Each output channel has its own one-word holding register.
// Routing comes either from in_sel (manual) or from an internal round-robin
// pointer (auto_en=1) that advances once per accepted word.
module demux1x4_stream #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           auto_en,
  input  logic [1:0]     in_sel,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready,
  output logic [4*W-1:0] out_data,
  output logic [1:0]     cur_sel,
  output logic [7:0]     acc_cnt
);

  logic [1:0]   ptr;
  logic [1:0]   tgt;
  logic         accept;
  logic [3:0]   wr_en;
  logic [3:0]   drain;
  logic [7:0]   cnt;
  logic [W-1:0] data_q [4];

  // Target channel: the round-robin pointer in auto mode, otherwise in_sel.
  always_comb begin
    tgt = in_sel;
    if (auto_en) begin
      tgt = ptr;
    end
  end

  // The target slot is free if it is empty or is being drained this cycle,
  // so in_ready depends on out_ready but never on in_valid.
  assign in_ready = ~out_valid[tgt] | out_ready[tgt];
  assign accept   = in_valid & in_ready;

  // One-hot write strobe: at most one channel is loaded per cycle.
  always_comb begin
    wr_en = '0;
    if (accept) begin
      wr_en[tgt] = 1'b1;
    end
  end

  // A channel drains when its sink takes it; idle ready bits do nothing.
  assign drain = out_valid & out_ready;

  // Valid flags: a write wins over a same-cycle drain, so the slot stays full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
    end else begin
      out_valid <= (out_valid & ~drain) | wr_en;
    end
  end

  // Holding registers: only a write changes them; a drain leaves the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_en[i]) begin
          data_q[i] <= in_data;
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_out
    assign out_data[g*W +: W] = data_q[g];
  end

  // Round-robin pointer advances only on an accept in auto mode; mode changes never reset it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept && auto_en) begin
      ptr <= ptr + 2'd1;
    end
  end

  // Accepted-word counter counts in both modes and wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign cur_sel = ptr;
  assign acc_cnt = cnt;

endmodule

// File: tb/tb_demux1x4_stream.sv
// tb_demux1x4_stream: table-driven directed vectors, hand-written reset
// sequences and a randomized run checked against a behavioural model.
module tb_demux1x4_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        auto_en;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [1:0]  cur_sel;
  logic [7:0]  acc_cnt;

  int n_vec = 0;
  int n_err = 0;

  demux1x4_stream #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .auto_en(auto_en), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cur_sel(cur_sel), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        auto_en;
    logic [1:0]  sel;
    logic        valid;
    logic [7:0]  data;
    logic [3:0]  ready;
    logic        exp_ir;
    logic [3:0]  exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_ptr;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t tbl[14];

  // Behavioural model: four slots, a pointer and a counter as plain integers.
  bit       m_full[4];
  int       m_word[4];
  int       m_ptr;
  int       m_cnt;

  function automatic int m_target();
    return auto_en ? m_ptr : int'(in_sel);
  endfunction

  function automatic logic m_ready();
    int t;
    t = m_target();
    return (!m_full[t]) || out_ready[t];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 0;
      m_word[i] = 0;
    end
    m_ptr = 0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    int  t;
    bit  acc;
    t   = m_target();
    acc = in_valid && m_ready();
    for (int i = 0; i < 4; i++) begin
      if (acc && i == t) begin
        m_full[i] = 1;
        m_word[i] = int'(in_data);
      end else if (m_full[i] && out_ready[i]) begin
        m_full[i] = 0;
      end
    end
    if (acc) begin
      m_cnt = (m_cnt + 1) % 256;
      if (auto_en) m_ptr = (m_ptr + 1) % 4;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0]  ev;
    logic [31:0] ed;
    for (int i = 0; i < 4; i++) begin
      ev[i]          = m_full[i];
      ed[i*8 +: 8]   = m_word[i][7:0];
    end
    cmp({tag, " out_valid"}, {28'd0, out_valid}, {28'd0, ev});
    cmp({tag, " out_data"}, out_data, ed);
    cmp({tag, " cur_sel"}, {30'd0, cur_sel}, m_ptr);
    cmp({tag, " acc_cnt"}, {24'd0, acc_cnt}, m_cnt);
  endtask

  task automatic drive(input logic a, input logic [1:0] s, input logic v,
                       input logic [7:0] d, input logic [3:0] r);
    auto_en   = a;
    in_sel    = s;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic check_reset_vals(input string tag);
    cmp({tag, " out_valid"}, {28'd0, out_valid}, 32'd0);
    cmp({tag, " out_data"}, out_data, 32'd0);
    cmp({tag, " cur_sel"}, {30'd0, cur_sel}, 32'd0);
    cmp({tag, " acc_cnt"}, {24'd0, acc_cnt}, 32'd0);
    cmp({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Hold reset with random inputs, check reset values, then release cleanly.
  task automatic apply_reset();
    rst_n = 1'b0;
    drive(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), 4'($urandom));
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_vals("reset");
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    // Manual routing, stall, same-cycle drain+write, round robin, mode toggle.
    tbl[0]  = '{1'b0, 2'd2, 1'b1, 8'hA5, 4'b0000, 1'b1, 4'b0100, 32'h00A50000, 2'd0, 8'd1};
    tbl[1]  = '{1'b0, 2'd2, 1'b1, 8'h77, 4'b0000, 1'b0, 4'b0100, 32'h00A50000, 2'd0, 8'd1};
    tbl[2]  = '{1'b0, 2'd1, 1'b1, 8'h5A, 4'b0000, 1'b1, 4'b0110, 32'h00A55A00, 2'd0, 8'd2};
    tbl[3]  = '{1'b0, 2'd2, 1'b1, 8'h3C, 4'b0100, 1'b1, 4'b0110, 32'h003C5A00, 2'd0, 8'd3};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 8'hEE, 4'b1111, 1'b1, 4'b0000, 32'h003C5A00, 2'd0, 8'd3};
    tbl[5]  = '{1'b1, 2'd2, 1'b1, 8'h11, 4'b0000, 1'b1, 4'b0001, 32'h003C5A11, 2'd1, 8'd4};
    tbl[6]  = '{1'b1, 2'd2, 1'b1, 8'h22, 4'b0000, 1'b1, 4'b0011, 32'h003C2211, 2'd2, 8'd5};
    tbl[7]  = '{1'b1, 2'd0, 1'b1, 8'h33, 4'b0000, 1'b1, 4'b0111, 32'h00332211, 2'd3, 8'd6};
    tbl[8]  = '{1'b1, 2'd1, 1'b1, 8'h44, 4'b0000, 1'b1, 4'b1111, 32'h44332211, 2'd0, 8'd7};
    tbl[9]  = '{1'b1, 2'd1, 1'b1, 8'h55, 4'b0000, 1'b0, 4'b1111, 32'h44332211, 2'd0, 8'd7};
    tbl[10] = '{1'b1, 2'd1, 1'b1, 8'h55, 4'b0001, 1'b1, 4'b1111, 32'h44332255, 2'd1, 8'd8};
    tbl[11] = '{1'b1, 2'd3, 1'b1, 8'h66, 4'b0000, 1'b0, 4'b1111, 32'h44332255, 2'd1, 8'd8};
    tbl[12] = '{1'b0, 2'd3, 1'b0, 8'h66, 4'b1110, 1'b1, 4'b0001, 32'h44332255, 2'd1, 8'd8};
    tbl[13] = '{1'b1, 2'd3, 1'b1, 8'h77, 4'b0000, 1'b1, 4'b0011, 32'h44337755, 2'd2, 8'd9};

    model_reset();
    apply_reset();

    for (int k = 0; k < 14; k++) begin
      string tag;
      tag = $sformatf("tbl%0d", k);
      drive(tbl[k].auto_en, tbl[k].sel, tbl[k].valid, tbl[k].data, tbl[k].ready);
      #1;
      cmp({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, tbl[k].exp_ir});
      @(posedge clk);
      #1;
      cmp({tag, " out_valid"}, {28'd0, out_valid}, {28'd0, tbl[k].exp_valid});
      cmp({tag, " out_data"}, out_data, tbl[k].exp_data);
      cmp({tag, " cur_sel"}, {30'd0, cur_sel}, {30'd0, tbl[k].exp_ptr});
      cmp({tag, " acc_cnt"}, {24'd0, acc_cnt}, {24'd0, tbl[k].exp_cnt});
    end

    // Fill all four channels with ptr=3, then reset between edges.
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'd0, 1'b1, 8'hA0 + 8'(k), 4'b0000);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 2'd3, 1'b1, 8'hD4, 4'b0000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cmp("prefill out_valid", {28'd0, out_valid}, 32'hF);
    cmp("prefill cur_sel", {30'd0, cur_sel}, 32'd3);
    cmp("prefill out_data", out_data, 32'hD4A2A1A0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // 256 accepts in auto mode with every sink ready: counter wraps to 0.
    for (int k = 0; k < 256; k++) begin
      drive(1'b1, 2'($urandom), 1'b1, 8'($urandom), 4'b1111);
      #1;
      cmp("wrap in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
      model_step();
      @(posedge clk);
      #1;
      check_model("wrap");
    end
    cmp("wrap acc_cnt", {24'd0, acc_cnt}, 32'd0);
    cmp("wrap cur_sel", {30'd0, cur_sel}, 32'd0);

    // Randomized traffic with mode toggles and occasional async resets.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        #1;
        cmp("rand async out_valid", {28'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        model_reset();
      end
      drive(($urandom_range(0, 9) < 6), 2'($urandom), ($urandom_range(0, 3) != 0),
            8'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
      #1;
      cmp("rand in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
      model_step();
      @(posedge clk);
      #1;
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
